// File: rtl/sw_pkg.sv
// Switch-wide defaults shared by the ingress, port FIFO and output stages.
package sw_pkg;

    localparam int W_WIDTH = 8;
    localparam int DEPTH   = 16;

    // Occupancy counter width: must hold 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int LEVEL_W = level_width(DEPTH);

    // Accepted operations in one cycle, encoded as {write, read}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_t;

endpackage

// File: rtl/sw_port_fifo_if.sv
// Write/read/status bundle between a per-port FIFO and its ingress/output users.
interface sw_port_fifo_if #(
    parameter int W_WIDTH = sw_pkg::W_WIDTH,
    parameter int DEPTH   = sw_pkg::DEPTH
);
    localparam int LW = sw_pkg::level_width(DEPTH);

    logic               wr_en;
    logic [W_WIDTH-1:0] wr_data;
    logic               rd_en;
    logic               err_clr;
    logic [W_WIDTH-1:0] fifo_data;
    logic               port_empty;
    logic               full;
    logic               almost_full;
    logic [LW-1:0]      level;
    logic               ovf;
    logic               udf;

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  fifo_data, port_empty, full, almost_full, level, ovf, udf
    );

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output fifo_data, port_empty, full, almost_full, level, ovf, udf
    );

endinterface

// File: rtl/sw_fifo_mem.sv
// Dual-port register array: synchronous write port, registered synchronous read port.
module sw_fifo_mem #(
    parameter int W_WIDTH = sw_pkg::W_WIDTH,
    parameter int DEPTH   = sw_pkg::DEPTH,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [W_WIDTH-1:0] wr_data,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [W_WIDTH-1:0] rd_data
);

    logic [W_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto plain storage; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // NOTE: non-blocking assignments make a same-edge write and read of one slot return the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sw_port_fifo.sv
// Per-output-port packet buffer: pointers, occupancy counter, back-pressure and sticky error flags.
module sw_port_fifo
    import sw_pkg::*;
#(
    parameter int W_WIDTH   = sw_pkg::W_WIDTH,
    parameter int DEPTH     = sw_pkg::DEPTH,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic          clk,
    input  logic          rst,
    sw_port_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          ovf_q;
    logic          udf_q;

    logic          empty_s;
    logic          full_s;
    logic          wr_acc;
    logic          rd_acc;
    logic          wr_rej;
    logic          rd_rej;
    fifo_op_t      op;

    // Status is decoded from the registered counter only, so no input reaches an output combinationally.
    assign empty_s = (level_q == '0);
    assign full_s  = (level_q == LW'(DEPTH));

    assign bus.port_empty  = empty_s;
    assign bus.full        = full_s;
    assign bus.almost_full = (level_q >= LW'(AF_THRESH));
    assign bus.level       = level_q;
    assign bus.ovf         = ovf_q;
    assign bus.udf         = udf_q;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        wr_acc = 1'b0;
        rd_acc = 1'b0;
        wr_rej = 1'b0;
        rd_rej = 1'b0;
        // A full FIFO can still take a write when the same cycle frees a slot.
        if (bus.wr_en) begin
            wr_acc = !full_s || bus.rd_en;
            wr_rej = full_s && !bus.rd_en;
        end
        // No fall-through: a read of an empty FIFO is rejected even alongside a write.
        if (bus.rd_en) begin
            rd_acc = !empty_s;
            rd_rej = empty_s;
        end
        op = fifo_op_t'({wr_acc, rd_acc});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);

            case (op)
                OP_WR:   level_q <= level_q + LW'(1);
                OP_RD:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase

            // A fresh error event outranks a clear arriving in the same cycle.
            if (wr_rej)           ovf_q <= 1'b1;
            else if (bus.err_clr) ovf_q <= 1'b0;

            if (rd_rej)           udf_q <= 1'b1;
            else if (bus.err_clr) udf_q <= 1'b0;
        end
    end

    sw_fifo_mem #(
        .W_WIDTH (W_WIDTH),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (bus.fifo_data)
    );

endmodule

// File: tb/tb_sw_port_fifo.sv
// Directed self-checking bench for sw_port_fifo: fill/drain, errors, simultaneous access, wrap, async reset.
module tb_sw_port_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    sw_port_fifo_if #(.W_WIDTH(8), .DEPTH(16)) bus ();

    sw_port_fifo #(.W_WIDTH(8), .DEPTH(16), .AF_THRESH(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of requests, let the edge take them, then sample 1 ns later.
    task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
        bus.wr_en   = wr;
        bus.wr_data = d;
        bus.rd_en   = rd;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_d;
    int         lvl;
    int         wr_cnt;
    bit         going_up;

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;

        // Reset state
        #12 rst = 1'b0;
        check("rst_empty", bus.port_empty, 1);
        check("rst_level", bus.level, 0);
        check("rst_full", bus.full, 0);
        check("rst_af", bus.almost_full, 0);
        check("rst_data", bus.fifo_data, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_udf", bus.udf, 0);

        // Fill with 0x11..0x20
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
            check("fill_level", bus.level, 32'(i + 1));
            check("fill_af", bus.almost_full, (i + 1 >= 14) ? 1 : 0);
            if (i == 0) check("fill_not_empty", bus.port_empty, 0);
        end
        check("fill_full", bus.full, 1);

        // Overflow: write while full, no read
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        check("ovf_set", bus.ovf, 1);
        check("ovf_level", bus.level, 16);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", bus.ovf, 0);

        // Full + read + write 0x55: both accepted, level pinned at 16
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check("fullrw_level", bus.level, 16);
        check("fullrw_data", bus.fifo_data, 8'h11);
        check("fullrw_ovf", bus.ovf, 0);

        // Drain: 0x12..0x20 then 0x55; 0xAA must never show up
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check("drain_data", bus.fifo_data, (i < 15) ? 32'(8'h12 + i) : 32'h55);
            check("drain_level", bus.level, 32'(15 - i));
        end
        check("drain_empty", bus.port_empty, 1);
        check("drain_full", bus.full, 0);

        // Underflow: read while empty, data holds
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("udf_set", bus.udf, 1);
        check("udf_data_hold", bus.fifo_data, 8'h55);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("udf_clr", bus.udf, 0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check("udf_set_wins", bus.udf, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("udf_clr2", bus.udf, 0);

        // Empty + read + write 0x66: write only, read rejected
        step(1'b1, 8'h66, 1'b1, 1'b0);
        check("emptyrw_level", bus.level, 1);
        check("emptyrw_udf", bus.udf, 1);
        check("emptyrw_data_hold", bus.fifo_data, 8'h55);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check("emptyrw_read", bus.fifo_data, 8'h66);
        check("emptyrw_level0", bus.level, 0);
        check("emptyrw_udf_clr", bus.udf, 0);

        // Wrap and almost_full: stream 40 words, level oscillating 13..15 once primed
        lvl      = 0;
        wr_cnt   = 0;
        going_up = 1'b1;
        while (wr_cnt < 40) begin
            if (going_up && lvl == 15)       going_up = 1'b0;
            else if (!going_up && lvl == 13) going_up = 1'b1;
            if (going_up) begin
                step(1'b1, 8'(8'h80 + wr_cnt), 1'b0, 1'b0);
                q.push_back(8'(8'h80 + wr_cnt));
                wr_cnt++;
                lvl++;
            end else begin
                step(1'b0, 8'h00, 1'b1, 1'b0);
                exp_d = q.pop_front();
                lvl--;
                check("wrap_data", bus.fifo_data, exp_d);
            end
            check("wrap_level", bus.level, 32'(lvl));
            check("wrap_af", bus.almost_full, (lvl >= 14) ? 1 : 0);
        end
        while (q.size() > 0) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            exp_d = q.pop_front();
            check("wrap_drain", bus.fifo_data, exp_d);
        end
        check("wrap_empty", bus.port_empty, 1);
        check("wrap_no_err", {bus.ovf, bus.udf}, 0);

        // Mid-operation asynchronous reset
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("mid_pre_data", bus.fifo_data, 8'h31);
        check("mid_pre_level", bus.level, 4);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_empty", bus.port_empty, 1);
        check("mid_rst_level", bus.level, 0);
        check("mid_rst_data", bus.fifo_data, 0);
        #2 rst = 1'b0;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        check("post_rst_level", bus.level, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("post_rst_data", bus.fifo_data, 8'h77);
        check("post_rst_empty", bus.port_empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_port_fifo.md
# sw_port_fifo

Per-output-port packet buffer of the simple switch. Sits directly upstream of the output-port FSM. Accepts bytes from the ingress routing logic and presents them on a registered read port (`rd_en` / `fifo_data` / `port_empty`) that the output FSM drains. Also provides occupancy, almost-full back-pressure and sticky overflow/underflow error flags.

## Interface
Parameters:
- `W_WIDTH`, 8, data word width.
- `DEPTH`, 16, number of entries; power of two, ≥4.
- `AF_THRESH`, `DEPTH-2`, level at or above which `almost_full` asserts.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: write request from the ingress stage.
- `wr_data` in `W_WIDTH`: write data.
- `rd_en` in 1: read request from the output FSM.
- `fifo_data` out `W_WIDTH`: registered read data.
- `port_empty` out 1: no stored entries.
- `full` out 1: level == `DEPTH`.
- `almost_full` out 1: level ≥ `AF_THRESH`.
- `level` out `$clog2(DEPTH)+1`: current occupancy, 0..`DEPTH`.
- `ovf` out 1: sticky overflow flag.
- `udf` out 1: sticky underflow flag.
- `err_clr` in 1: synchronous clear of `ovf`/`udf`.

## Operation
- Storage is a circular buffer with `$clog2(DEPTH)`-bit write and read pointers. Pointers wrap naturally from `DEPTH-1` to 0.
- `level` is a separate counter; `port_empty`, `full` and `almost_full` are all decoded from the registered `level`.
- Accepted write: `wr_en && (!full || rd_en)`.
  - Stores `wr_data` at the write pointer and increments the write pointer.
- Accepted read: `rd_en && !port_empty`.
  - Loads the entry at the read pointer into `fifo_data` and increments the read pointer.
- Level update per cycle: +1 for a write only, −1 for a read only, unchanged for both or neither.
- Simultaneous read and write:
  - When full: both are accepted and `level` stays at `DEPTH`.
  - When empty: only the write is accepted. There is no fall-through; the read is rejected and sets `udf`.
- Rejected write (`wr_en && full && !rd_en`): data is dropped, pointers are unchanged, `ovf` is set.
- Rejected read (`rd_en && port_empty`): `fifo_data` holds its previous value, `udf` is set.
- `err_clr` clears both sticky flags. If a set event and `err_clr` occur in the same cycle, the set wins.
- `fifo_data` changes only on accepted reads.
- Reset values:
  - Pointers 0, `level` 0, `fifo_data` 0.
  - `port_empty`=1, `full`=0, `almost_full`=0 (with `AF_THRESH`≥1), `ovf`=0, `udf`=0.
- The memory array is not reset.
- Reset asserted mid-operation discards all contents immediately (asynchronous reset). Outputs return to their reset values without waiting for a clock edge.

## Timing
- Write-to-visible latency: a write accepted at edge N raises `level`/clears `port_empty` after edge N. A read can then be issued in cycle N+1.
- Read latency is 1 cycle: `rd_en` sampled at edge N gives `fifo_data` valid after edge N. The output FSM samples it in the following cycle.
- Flags are updated on the same edge as `level`. There are no combinational paths from inputs to outputs.
- Throughput is one write and one read per cycle, sustained.

## Structure
- The shared package `sw_pkg` holds the switch-wide defaults: `W_WIDTH`, `DEPTH`, and a `level_t`-style width constant. These are reused by the ingress and output stages.
- Sub-module `sw_fifo_mem`: a dual-port register array with a synchronous write port and a synchronous registered read port (read enable + address). It owns no control logic.
- Pointers, the level counter, the flags and the accept logic live in `sw_port_fifo`.

## Test plan
- **Reset, fill, drain:** after reset, write 0x11..0x1F and 0x20 (16 words), then read 16.
  - `port_empty`=1, `level`=0 after reset.
  - `full`=1 and `level`=16 after the 16th write.
  - Read data matches 0x11..0x20 in order, each one cycle after its `rd_en`.
  - `port_empty` rises after the last read.
- **Overflow:** with the FIFO full, write 0xAA with `rd_en`=0.
  - `ovf`=1, `level` stays 16, and 0xAA never appears on the read side.
  - Pulsing `err_clr` returns `ovf` to 0.
- **Underflow:** with the FIFO empty, assert `rd_en`.
  - `udf`=1 and `fifo_data` is unchanged.
  - Assert `udf`-causing read and `err_clr` together: `udf` stays 1.
- **Simultaneous access:**
  - Full + read + write of 0x55: `level` stays 16, and 0x55 is read out last.
  - Empty + read + write of 0x66: `level` becomes 1, `udf`=1, and the next read returns 0x66.
- **Wrap and almost_full:** stream 40 words while reading to keep `level` cycling 13..15.
  - Data order is preserved across the pointer wrap.
  - `almost_full`=1 exactly when `level`≥14.
- **Mid-operation reset:** after 5 writes, assert `rst` between clock edges.
  - `port_empty`=1, `level`=0 and `fifo_data`=0 immediately.
  - The first write after reset is read back correctly.
